// File: rtl/busqueda_ctrl_pkg.sv
// Shared definitions for the busqueda frame controller: defaults, FSM encoding
// and the field layout of the {en, addr, data} RAM write bus.
package busqueda_ctrl_pkg;

    localparam int ADDR_W_DEF  = 11;
    localparam int PX_W_DEF    = 24;
    localparam int FCNT_W_DEF  = 16;
    localparam int STATS_W     = 24;
    localparam int WR_DATA_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_REF,
        S_LOAD_ACT,
        S_START,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    // Data field is PX_W+1 bits wide; its MSB is a tag bit the loader drives as 0.
    function automatic int wr_w(input int addr_w, input int px_w);
        return addr_w + px_w + 2;
    endfunction

    function automatic int wr_en_bit(input int addr_w, input int px_w);
        return addr_w + px_w + 1;
    endfunction

    function automatic int wr_addr_lsb(input int px_w);
        return px_w + 1;
    endfunction

endpackage

// File: rtl/busqueda_wr_mux.sv
// Selects between controller-side and search-engine-side writes for one RAM.
module busqueda_wr_mux
    import busqueda_ctrl_pkg::*;
#(
    parameter int W = wr_w(ADDR_W_DEF, PX_W_DEF)
) (
    input  logic         sel_ctrl,
    input  logic [W-1:0] ctrl_wr,
    input  logic [W-1:0] bq_wr,
    output logic [W-1:0] ram_wr
);

    assign ram_wr = sel_ctrl ? ctrl_wr : bq_wr;

endmodule

// File: rtl/busqueda_ctrl.sv
// Frame controller: loads ref/act RAMs from the pixel stream, then hands off to
// the search engine. Define BUSQUEDA_CTRL_STATS_EN to add the srch_cycles counter.
module busqueda_ctrl
    import busqueda_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PX_W   = PX_W_DEF,
    parameter int FCNT_W = FCNT_W_DEF
) (
    input  logic                     clk_fsm,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        cfg_window_limit,
    input  logic                     frm_start,
    input  logic                     px_valid,
    input  logic [PX_W-1:0]          px_data,
    output logic                     px_ready,
    output logic                     srch_start,
    input  logic                     srch_finish,
    input  logic                     srch_idle,
    output logic [ADDR_W-1:0]        window_limit,
    output logic [1:0]               cont_img,
    output logic                     busy,
    output logic                     frame_done,
    output logic [FCNT_W-1:0]        frame_cnt,
`ifdef BUSQUEDA_CTRL_STATS_EN
    output logic [STATS_W-1:0]       srch_cycles,
`endif
    input  logic [ADDR_W+PX_W+1:0]   bq_ref_wr,
    input  logic [ADDR_W+PX_W+1:0]   bq_act_wr,
    output logic [ADDR_W+PX_W+1:0]   ram_ref_wr,
    output logic [ADDR_W+PX_W+1:0]   ram_act_wr
);

    localparam int WR_W     = wr_w(ADDR_W, PX_W);
    localparam int EN_BIT   = wr_en_bit(ADDR_W, PX_W);
    localparam int ADDR_LSB = wr_addr_lsb(PX_W);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] load_addr;
    logic              load_sel;
    logic              xfer;
    logic              last_px;
    logic              accept;
    logic [WR_W-1:0]   ctrl_ref_wr;
    logic [WR_W-1:0]   ctrl_act_wr;

    assign load_sel = (state == S_LOAD_REF) || (state == S_LOAD_ACT);
    assign xfer     = load_sel && px_valid;
    assign last_px  = (load_addr == window_limit);
    assign accept   = (state == S_IDLE) && frm_start && srch_idle;

    // NOTE: handshake/pulse outputs decode from the state register only, so the
    // async reset clears them immediately without needing their own flops.
    always_comb begin
        state_nxt  = state;
        px_ready   = 1'b0;
        srch_start = 1'b0;
        frame_done = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:     if (accept) state_nxt = S_LOAD_REF;
            S_LOAD_REF: begin
                px_ready = 1'b1;
                if (xfer && last_px) state_nxt = S_LOAD_ACT;
            end
            S_LOAD_ACT: begin
                px_ready = 1'b1;
                if (xfer && last_px) state_nxt = S_START;
            end
            S_START: begin
                srch_start = 1'b1;
                state_nxt  = S_WAIT_FIN;
            end
            S_WAIT_FIN: if (srch_finish) state_nxt = S_DONE;
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_fsm or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            load_addr    <= '0;
            window_limit <= '0;
            cont_img     <= '0;
            frame_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                window_limit <= cfg_window_limit;
                load_addr    <= '0;
            end else if (xfer) begin
                load_addr <= last_px ? '0 : load_addr + 1'b1;
            end
            if (state == S_DONE) begin
                cont_img  <= cont_img + 2'd1;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

`ifdef BUSQUEDA_CTRL_STATS_EN
    always_ff @(posedge clk_fsm or negedge rst_n) begin
        if (!rst_n) begin
            srch_cycles <= '0;
        end else if (state == S_START) begin
            srch_cycles <= '0;
        end else if ((state == S_WAIT_FIN) && (srch_cycles != {STATS_W{1'b1}})) begin
            srch_cycles <= srch_cycles + 1'b1;
        end
    end
`endif

    // Tag bit (MSB of the data field) stays 0 for loader writes.
    always_comb begin
        ctrl_ref_wr = '0;
        ctrl_ref_wr[EN_BIT]                  = xfer && (state == S_LOAD_REF);
        ctrl_ref_wr[ADDR_LSB +: ADDR_W]      = load_addr;
        ctrl_ref_wr[WR_DATA_LSB +: PX_W]     = px_data;
        ctrl_act_wr = '0;
        ctrl_act_wr[EN_BIT]                  = xfer && (state == S_LOAD_ACT);
        ctrl_act_wr[ADDR_LSB +: ADDR_W]      = load_addr;
        ctrl_act_wr[WR_DATA_LSB +: PX_W]     = px_data;
    end

    busqueda_wr_mux #(.W(WR_W)) u_ref_mux (
        .sel_ctrl (load_sel),
        .ctrl_wr  (ctrl_ref_wr),
        .bq_wr    (bq_ref_wr),
        .ram_wr   (ram_ref_wr)
    );

    busqueda_wr_mux #(.W(WR_W)) u_act_mux (
        .sel_ctrl (load_sel),
        .ctrl_wr  (ctrl_act_wr),
        .bq_wr    (bq_act_wr),
        .ram_wr   (ram_act_wr)
    );

endmodule

// File: tb/tb_busqueda_ctrl.sv
// Directed bench for busqueda_ctrl (default parameters); STATS checks follow
// BUSQUEDA_CTRL_STATS_EN when it is defined.
module tb_busqueda_ctrl;

    localparam logic [36:0] BQ_REF = {1'b1, 11'h055, 25'h0123456};
    localparam logic [36:0] BQ_ACT = {1'b1, 11'h0AA, 25'h1654321};

    logic        clk_fsm;
    logic        rst_n;
    logic [10:0] cfg_window_limit;
    logic        frm_start;
    logic        px_valid;
    logic [23:0] px_data;
    logic        px_ready;
    logic        srch_start;
    logic        srch_finish;
    logic        srch_idle;
    logic [10:0] window_limit;
    logic [1:0]  cont_img;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
`ifdef BUSQUEDA_CTRL_STATS_EN
    logic [23:0] srch_cycles;
`endif
    logic [36:0] bq_ref_wr;
    logic [36:0] bq_act_wr;
    logic [36:0] ram_ref_wr;
    logic [36:0] ram_act_wr;

    int n_tests     = 0;
    int n_fail      = 0;
    int done_pulses = 0;

    busqueda_ctrl dut (
        .clk_fsm          (clk_fsm),
        .rst_n            (rst_n),
        .cfg_window_limit (cfg_window_limit),
        .frm_start        (frm_start),
        .px_valid         (px_valid),
        .px_data          (px_data),
        .px_ready         (px_ready),
        .srch_start       (srch_start),
        .srch_finish      (srch_finish),
        .srch_idle        (srch_idle),
        .window_limit     (window_limit),
        .cont_img         (cont_img),
        .busy             (busy),
        .frame_done       (frame_done),
        .frame_cnt        (frame_cnt),
`ifdef BUSQUEDA_CTRL_STATS_EN
        .srch_cycles      (srch_cycles),
`endif
        .bq_ref_wr        (bq_ref_wr),
        .bq_act_wr        (bq_act_wr),
        .ram_ref_wr       (ram_ref_wr),
        .ram_act_wr       (ram_act_wr)
    );

    initial clk_fsm = 1'b0;
    always #5 clk_fsm = ~clk_fsm;

    always @(posedge clk_fsm) if (frame_done === 1'b1) done_pulses++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fsm);
        #1;
    endtask

    task automatic start_frame(input logic [10:0] limit, input logic [1:0] exp_img);
        cfg_window_limit = limit;
        srch_idle        = 1'b1;
        frm_start        = 1'b1;
        tick();
        frm_start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_limit", window_limit, limit);
        check("start_img", cont_img, exp_img);
    endtask

    task automatic push_px(input bit is_ref, input logic [10:0] addr, input logic [23:0] data);
        px_valid = 1'b1;
        px_data  = data;
        #1;
        check("px_ready", px_ready, 1'b1);
        if (is_ref) begin
            check("ref_wr", ram_ref_wr, {1'b1, addr, 1'b0, data});
            check("act_en_off", ram_act_wr[36], 1'b0);
        end else begin
            check("act_wr", ram_act_wr, {1'b1, addr, 1'b0, data});
            check("ref_en_off", ram_ref_wr[36], 1'b0);
        end
        tick();
        px_valid = 1'b0;
    endtask

    task automatic idle_px();
        px_valid = 1'b0;
        #1;
        check("stall_ready", px_ready, 1'b1);
        check("stall_ref_en", ram_ref_wr[36], 1'b0);
        check("stall_act_en", ram_act_wr[36], 1'b0);
        tick();
    endtask

    // Entered one cycle into WAIT_FIN; ends back in IDLE.
    task automatic finish_frame(input logic [15:0] exp_cnt, input logic [1:0] exp_img);
        srch_finish = 1'b1;
        tick();
        srch_finish = 1'b0;
        check("done_pulse", frame_done, 1'b1);
        tick();
        check("done_clear", frame_done, 1'b0);
        check("done_idle", busy, 1'b0);
        check("frame_cnt", frame_cnt, exp_cnt);
        check("cont_img", cont_img, exp_img);
    endtask

    initial begin
        rst_n            = 1'b0;
        cfg_window_limit = '0;
        frm_start        = 1'b0;
        px_valid         = 1'b0;
        px_data          = '0;
        srch_finish      = 1'b0;
        srch_idle        = 1'b1;
        bq_ref_wr        = BQ_REF;
        bq_act_wr        = BQ_ACT;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_ready", px_ready, 1'b0);
        check("rst_start", srch_start, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_limit", window_limit, 11'd0);
        check("rst_img", cont_img, 2'd0);
        check("rst_cnt", frame_cnt, 16'd0);
        check("idle_ref_pass", ram_ref_wr, BQ_REF);
        check("idle_act_pass", ram_act_wr, BQ_ACT);
        #10 rst_n = 1'b1;
        tick();

        // Frame 1: limit 3, eight pixels back to back.
        start_frame(11'd3, 2'd0);
        for (int i = 0; i < 4; i++) push_px(1'b1, 11'(i), 24'hA00000 + 24'(i));
        for (int i = 0; i < 4; i++) push_px(1'b0, 11'(i), 24'hB00000 + 24'(i));
        check("srch_start_hi", srch_start, 1'b1);
        tick();
        check("srch_start_lo", srch_start, 1'b0);
        frm_start = 1'b1;
        bq_ref_wr = {1'b1, 11'h007, 25'h1ABCDEF};
        #1;
        check("wait_ref_pass", ram_ref_wr, {1'b1, 11'h007, 25'h1ABCDEF});
        check("wait_act_pass", ram_act_wr, BQ_ACT);
        check("wait_ready", px_ready, 1'b0);
        tick();
        frm_start = 1'b0;
        bq_ref_wr = BQ_REF;
        check("wait_hold", busy, 1'b1);
        finish_frame(16'd1, 2'd1);
        tick();
        check("start_not_queued", busy, 1'b0);

        // Stray finish and start without srch_idle must be ignored.
        srch_finish = 1'b1;
        tick();
        srch_finish = 1'b0;
        check("stray_finish_busy", busy, 1'b0);
        check("stray_finish_cnt", frame_cnt, 16'd1);
        srch_idle = 1'b0;
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
        check("no_idle_no_start", busy, 1'b0);

        // Frame 2: limit 1 with stalls and a mid-frame cfg change.
        start_frame(11'd1, 2'd1);
        push_px(1'b1, 11'd0, 24'h111111);
        idle_px();
        cfg_window_limit = 11'd5;
        push_px(1'b1, 11'd1, 24'h222222);
        idle_px();
        push_px(1'b0, 11'd0, 24'h333333);
        idle_px();
        push_px(1'b0, 11'd1, 24'h444444);
        check("f2_start", srch_start, 1'b1);
        check("f2_limit_kept", window_limit, 11'd1);
        tick();
        finish_frame(16'd2, 2'd2);

        // Frames 3..5: limit 0, one pixel per RAM; cont_img wraps.
        for (int f = 3; f <= 5; f++) begin
            start_frame(11'd0, 2'((f - 1) % 4));
            push_px(1'b1, 11'd0, 24'hC00000 + 24'(f));
            push_px(1'b0, 11'd0, 24'hD00000 + 24'(f));
            check("lim0_start", srch_start, 1'b1);
            tick();
            finish_frame(16'(f), 2'(f % 4));
        end
        check("done_pulses", 64'(done_pulses), 64'd5);

        // Reset during LOAD_ACT at address 2.
        start_frame(11'd3, 2'd1);
        for (int i = 0; i < 4; i++) push_px(1'b1, 11'(i), 24'hE00000 + 24'(i));
        for (int i = 0; i < 2; i++) push_px(1'b0, 11'(i), 24'hF00000 + 24'(i));
        px_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", px_ready, 1'b0);
        check("mid_rst_limit", window_limit, 11'd0);
        check("mid_rst_img", cont_img, 2'd0);
        check("mid_rst_cnt", frame_cnt, 16'd0);
        check("mid_rst_act_pass", ram_act_wr, BQ_ACT);
        px_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_no_done", 64'(done_pulses), 64'd5);
        start_frame(11'd0, 2'd0);
        push_px(1'b1, 11'd0, 24'h5A5A5A);
        push_px(1'b0, 11'd0, 24'hA5A5A5);
        tick();
        finish_frame(16'd1, 2'd1);

`ifdef BUSQUEDA_CTRL_STATS_EN
        start_frame(11'd0, 2'd1);
        push_px(1'b1, 11'd0, 24'h010203);
        push_px(1'b0, 11'd0, 24'h040506);
        tick();
        check("stats_clear", srch_cycles, 24'd0);
        repeat (99) tick();
        srch_finish = 1'b1;
        tick();
        srch_finish = 1'b0;
        check("stats_100", srch_cycles, 24'd100);
        repeat (3) tick();
        check("stats_held", srch_cycles, 24'd100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/busqueda_ctrl.md
BUSQUEDA_CTRL -- requirements
Module: busqueda_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 11, RAM address width; PX_W, default 24, pixel width; FCNT_W, default 16, frame counter width.
REQ-002 clk_fsm  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cfg_window_limit  in  ADDR_W  last pixel address of the frame.
REQ-005 frm_start  in  1  host request to process one frame.
REQ-006 px_valid  in  1  host pixel stream valid.
REQ-007 px_data  in  PX_W  host pixel RGB.
REQ-008 px_ready  out  1  controller accepts a pixel.
REQ-009 srch_start  out  1  start pulse to the search engine.
REQ-010 srch_finish  in  1  finish pulse from the search engine.
REQ-011 srch_idle  in  1  search engine idle flag.
REQ-012 window_limit  out  ADDR_W  latched limit driven to the search engine.
REQ-013 cont_img  out  2  frame tag driven to the search engine.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 frame_done  out  1  one-cycle pulse per completed frame.
REQ-016 frame_cnt  out  FCNT_W  completed frame count.
REQ-017 bq_ref_wr  in  1+ADDR_W+PX_W+1  search-engine ref write: {en, addr, data}.
REQ-018 bq_act_wr  in  1+ADDR_W+PX_W+1  search-engine act write: {en, addr, data}.
REQ-019 ram_ref_wr  out  1+ADDR_W+PX_W+1  muxed write port to the ref RAM.
REQ-020 ram_act_wr  out  1+ADDR_W+PX_W+1  muxed write port to the act RAM.

Function
REQ-021 FSM states SHALL be IDLE, LOAD_REF, LOAD_ACT, START, WAIT_FIN and DONE.
REQ-022 IDLE: frm_start=1 and srch_idle=1 -> latch cfg_window_limit into window_limit, load_addr<=0, go to LOAD_REF; otherwise stay in IDLE.
REQ-023 px_ready SHALL be 1 only in LOAD_REF and LOAD_ACT; a transfer occurs when px_valid=1 and px_ready=1.
REQ-024 LOAD_REF transfer: ram_ref_wr={1, load_addr, {1'b0, px_data}}, combinational in the same cycle; load_addr==window_limit -> load_addr<=0 and go to LOAD_ACT, else load_addr+1.
REQ-025 LOAD_ACT SHALL behave identically on ram_act_wr; load_addr==window_limit -> go to START.
REQ-026 START: srch_start=1 for exactly one cycle, then go to WAIT_FIN.
REQ-027 WAIT_FIN: srch_finish=1 -> go to DONE; the FSM stays in WAIT_FIN with no timeout.
REQ-028 DONE: frame_done=1 for one cycle; cont_img+1 with wrap 3->0; frame_cnt+1 with wrap at 2^FCNT_W; then go to IDLE.
REQ-029 Port mux: in LOAD_REF/LOAD_ACT, ram_*_wr SHALL be driven by the controller and bq_*_wr ignored; in all other states ram_*_wr=bq_*_wr, combinational.
REQ-030 In LOAD states with no transfer, the controller-side write enable SHALL be 0.
REQ-031 frm_start received while busy=1 SHALL be ignored and not queued.
REQ-032 window_limit SHALL stay constant from latch until the next IDLE exit; cfg_window_limit changes mid-frame have no effect.
REQ-033 window_limit=0 SHALL load exactly one pixel per RAM.
REQ-034 srch_finish outside WAIT_FIN SHALL be ignored.

Reset
REQ-035 rst_n=0 SHALL asynchronously force: state IDLE, load_addr 0, window_limit 0, cont_img 0, frame_cnt 0, srch_start 0, frame_done 0, px_ready 0, busy 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame with no frame_done; ram_*_wr then passes bq_*_wr.

Configuration
REQ-037 Macro BUSQUEDA_CTRL_STATS_EN defined: adds output srch_cycles (24 bits), cleared in START, +1 per WAIT_FIN cycle, saturating at 2^24-1, held after DONE, reset 0.
REQ-038 Macro BUSQUEDA_CTRL_STATS_EN undefined: port srch_cycles and its counter are absent; all other behaviour is identical.

Structure
REQ-039 A shared package SHALL hold ADDR_W/PX_W defaults, the state encoding, and field offsets of the {en, addr, data} write bus.
REQ-040 The write-port mux SHALL be sub-module busqueda_wr_mux, instantiated once per RAM.

Verification
REQ-041 limit=3, 8 pixels with no stalls -> ref addr 0..3 then act addr 0..3 written with bit24=0; srch_start pulse 1 cycle after the last pixel.
REQ-042 px_valid toggling 1/0 during load -> only handshaked pixels written, addresses contiguous, no gaps or duplicates.
REQ-043 Four frames -> cont_img sequence 0,1,2,3, then 0 on the fifth frame; frame_cnt=5; frame_done pulses 5 times.
REQ-044 frm_start pulsed during WAIT_FIN -> ignored; bq_ref_wr en/addr 0x7/data 0x1ABCDEF appears unchanged on ram_ref_wr.
REQ-045 rst_n low during LOAD_ACT at addr 2 -> all outputs at reset values the same cycle; no frame_done; next frame starts at addr 0.
REQ-046 With BUSQUEDA_CTRL_STATS_EN, finish 100 cycles after START -> srch_cycles=100, held until the next START.
